// File: rtl/storage_cmdq_pkg.sv
// Shared hd_parameter definitions for the storage command queue: default sizes and entry-state encodings.
package storage_cmdq_pkg;
  localparam int CMD_DATA_WIDTH_DEF = 64;
  localparam int MAX_CMDQ_DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ISSUED  = 2'd2,
    ST_DONE    = 2'd3
  } entry_state_e;
endpackage

// File: rtl/storage_cmdq_mem.sv
// Command data array: one synchronous write port, one asynchronous read port, no reset.
module storageq_mem #(
  parameter  int W     = 64,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/storage_cmdq.sv
// Storage command queue: in-order enqueue/issue, out-of-order completion, in-order retire.
// Optional sticky protocol error flag enabled by defining SQ_ERR_STICKY_EN.
module storage_cmdq import storage_cmdq_pkg::*; #(
  parameter  int CMD_DATA_WIDTH = CMD_DATA_WIDTH_DEF,
  parameter  int MAX_CMDQ_DEPTH = MAX_CMDQ_DEPTH_DEF,
  localparam int IW             = $clog2(MAX_CMDQ_DEPTH)
) (
  input  logic                      clock_fpga,
  input  logic                      reset_n,
  input  logic                      sq_select,
  input  logic [CMD_DATA_WIDTH-1:0] cmd_in,
  output logic                      sq_ready,
  output logic                      issue_valid,
  output logic [CMD_DATA_WIDTH-1:0] issue_cmd,
  input  logic                      issue_ready,
  input  logic                      done_valid,
  input  logic [IW-1:0]             done_index,
  output logic                      status_update_enable,
  output logic [7:0]                cmdq_index,
  output logic [IW:0]               count,
  input  logic                      err_clear,
  output logic                      sq_err
);
  entry_state_e  r_state [MAX_CMDQ_DEPTH];
  logic [IW-1:0] r_tail, r_cur, r_head;
  logic [IW:0]   r_count;
  logic          r_sue;
  logic [7:0]    r_idx;

  logic w_full, w_enq, w_iss, w_done, w_ret;

  assign w_full      = (r_count == (IW+1)'(MAX_CMDQ_DEPTH));
  assign sq_ready    = !w_full;
  assign w_enq       = sq_select && !w_full;
  assign issue_valid = (r_state[r_cur] == ST_PENDING);
  assign w_iss       = issue_valid && issue_ready;
  // Judged on the pre-edge state, so an entry issued this cycle cannot complete this cycle.
  assign w_done      = done_valid && (r_state[done_index] == ST_ISSUED);
  assign w_ret       = (r_state[r_head] == ST_DONE);

  storageq_mem #(.W(CMD_DATA_WIDTH), .DEPTH(MAX_CMDQ_DEPTH)) u_mem (
    .i_clk  (clock_fpga),
    .i_we   (w_enq),
    .i_waddr(r_tail),
    .i_wdata(cmd_in),
    .i_raddr(r_cur),
    .o_rdata(issue_cmd)
  );

  // Each event acts on an entry in a different state, so the per-entry writes never collide.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_CMDQ_DEPTH; i++) r_state[i] <= ST_FREE;
      r_tail  <= '0;
      r_cur   <= '0;
      r_head  <= '0;
      r_count <= '0;
      r_sue   <= 1'b0;
      r_idx   <= 8'd0;
    end else begin
      if (w_enq) begin
        r_state[r_tail] <= ST_PENDING;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_iss) begin
        r_state[r_cur] <= ST_ISSUED;
        r_cur          <= r_cur + 1'b1;
      end
      if (w_done) r_state[done_index] <= ST_DONE;
      r_sue <= w_ret;
      if (w_ret) begin
        r_state[r_head] <= ST_FREE;
        r_head          <= r_head + 1'b1;
        r_idx           <= {{(8-IW){1'b0}}, r_head};
      end
      case ({w_enq, w_ret})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign status_update_enable = r_sue;
  assign cmdq_index           = r_idx;
  assign count                = r_count;

`ifdef SQ_ERR_STICKY_EN
  logic r_err;
  logic w_err_set;
  assign w_err_set = (sq_select && w_full) || (done_valid && !w_done);

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n)       r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (err_clear) r_err <= 1'b0;
  end
  assign sq_err = r_err;
`else
  logic w_unused_err_clear;
  assign w_unused_err_clear = err_clear;
  assign sq_err             = 1'b0;
`endif
endmodule

// File: tb/tb_storage_cmdq.sv
// Directed bench: a depth-4 instance for full/ordering/error cases, a depth-32 instance for wrap, full+retire and reset.
module tb_storage_cmdq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

`ifdef SQ_ERR_STICKY_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // depth-4 instance
  logic        a_rst_n, a_sel, a_rdy, a_iv, a_irdy, a_dv, a_sue, a_ec, a_err;
  logic [15:0] a_cmd, a_icmd;
  logic [1:0]  a_di;
  logic [7:0]  a_ci;
  logic [2:0]  a_cnt;

  storage_cmdq #(.CMD_DATA_WIDTH(16), .MAX_CMDQ_DEPTH(4)) u_a (
    .clock_fpga(clk), .reset_n(a_rst_n), .sq_select(a_sel), .cmd_in(a_cmd),
    .sq_ready(a_rdy), .issue_valid(a_iv), .issue_cmd(a_icmd), .issue_ready(a_irdy),
    .done_valid(a_dv), .done_index(a_di), .status_update_enable(a_sue),
    .cmdq_index(a_ci), .count(a_cnt), .err_clear(a_ec), .sq_err(a_err)
  );

  // depth-32 instance
  logic        b_rst_n, b_sel, b_rdy, b_iv, b_irdy, b_dv, b_sue, b_ec, b_err;
  logic [63:0] b_cmd, b_icmd;
  logic [4:0]  b_di;
  logic [7:0]  b_ci;
  logic [5:0]  b_cnt;

  storage_cmdq #(.CMD_DATA_WIDTH(64), .MAX_CMDQ_DEPTH(32)) u_b (
    .clock_fpga(clk), .reset_n(b_rst_n), .sq_select(b_sel), .cmd_in(b_cmd),
    .sq_ready(b_rdy), .issue_valid(b_iv), .issue_cmd(b_icmd), .issue_ready(b_irdy),
    .done_valid(b_dv), .done_index(b_di), .status_update_enable(b_sue),
    .cmdq_index(b_ci), .count(b_cnt), .err_clear(b_ec), .sq_err(b_err)
  );

  initial begin
    a_rst_n = 1'b0; a_sel = 1'b0; a_cmd = '0; a_irdy = 1'b0; a_dv = 1'b0; a_di = '0; a_ec = 1'b0;
    b_rst_n = 1'b0; b_sel = 1'b0; b_cmd = '0; b_irdy = 1'b0; b_dv = 1'b0; b_di = '0; b_ec = 1'b0;
    #12;
    chk("a_rst_count", a_cnt, 0);
    chk("a_rst_ready", a_rdy, 1);
    chk("a_rst_iv",    a_iv,  0);
    chk("a_rst_sue",   a_sue, 0);
    chk("a_rst_idx",   a_ci,  0);
    chk("a_rst_err",   a_err, 0);
    chk("b_rst_count", b_cnt, 0);
    tick;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick;

    // fill depth-4 queue, then a dropped 5th enqueue
    a_sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_cmd = 16'hA000 + 16'(k);
      tick;
    end
    chk("a_full_count", a_cnt, 4);
    chk("a_full_ready", a_rdy, 0);
    a_cmd = 16'hEEEE;
    tick;
    a_sel = 1'b0;
    chk("a_drop_count", a_cnt, 4);
    chk("a_drop_err",   a_err, ERR_EXP);
    chk("a_head_iv",    a_iv,  1);
    chk("a_head_cmd",   a_icmd, 16'hA000);
    a_ec = 1'b1;
    tick;
    a_ec = 1'b0;
    chk("a_err_clr", a_err, 0);

    // issue A,B; complete B then A
    a_irdy = 1'b1;
    tick;
    chk("a_iss1_cmd", a_icmd, 16'hA001);
    tick;
    a_irdy = 1'b0;
    chk("a_iss2_cmd", a_icmd, 16'hA002);
    chk("a_iss2_iv",  a_iv, 1);
    a_dv = 1'b1; a_di = 2'd1;
    tick;
    chk("a_doneB_sue", a_sue, 0);
    a_di = 2'd0;
    tick;
    a_dv = 1'b0;
    chk("a_doneA_sue", a_sue, 0);
    tick;
    chk("a_ret0_sue", a_sue, 1);
    chk("a_ret0_idx", a_ci,  8'h00);
    chk("a_ret0_cnt", a_cnt, 3);
    tick;
    chk("a_ret1_sue", a_sue, 1);
    chk("a_ret1_idx", a_ci,  8'h01);
    chk("a_ret1_cnt", a_cnt, 2);
    tick;
    chk("a_idle_sue", a_sue, 0);
    chk("a_idle_idx", a_ci,  8'h01);

    // done on a PENDING entry is ignored
    a_dv = 1'b1; a_di = 2'd2;
    tick;
    a_dv = 1'b0;
    chk("a_bad_err", a_err, ERR_EXP);
    chk("a_bad_iv",  a_iv,  1);
    chk("a_bad_cmd", a_icmd, 16'hA002);
    chk("a_bad_cnt", a_cnt, 2);
    tick;
    chk("a_bad_sue", a_sue, 0);
    a_irdy = 1'b1;
    tick;
    a_irdy = 1'b0;
    a_dv = 1'b1; a_di = 2'd2;
    tick;
    a_dv = 1'b0;
    tick;
    chk("a_ret2_sue", a_sue, 1);
    chk("a_ret2_idx", a_ci,  8'h02);
    chk("a_ret2_cnt", a_cnt, 1);

    // 40 full lifecycles on depth 32: wrap and data integrity
    for (int i = 0; i < 40; i++) begin
      b_sel = 1'b1; b_cmd = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0001;
      tick;
      b_sel = 1'b0; b_irdy = 1'b1;
      #1;
      chk("b_wrap_data", b_icmd, 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0001);
      tick;
      b_irdy = 1'b0;
      b_dv = 1'b1; b_di = 5'(i % 32);
      tick;
      b_dv = 1'b0;
      tick;
      chk("b_wrap_idx", {b_sue, b_ci}, {1'b1, 8'(i % 32)});
    end
    chk("b_wrap_cnt", b_cnt, 0);

    // full queue, head DONE and enqueue in the same cycle
    b_sel = 1'b1;
    for (int j = 0; j < 32; j++) begin
      b_cmd = 64'hF000 + 64'(j);
      tick;
    end
    b_sel = 1'b0;
    chk("b_full_cnt", b_cnt, 32);
    chk("b_full_rdy", b_rdy, 0);
    b_irdy = 1'b1;
    tick;
    b_irdy = 1'b0;
    chk("b_full_next", b_icmd, 64'hF001);
    b_dv = 1'b1; b_di = 5'd8;
    tick;
    b_dv = 1'b0;
    b_sel = 1'b1; b_cmd = 64'hDEAD;
    tick;
    b_sel = 1'b0;
    chk("b_rc_cnt", b_cnt, 31);
    chk("b_rc_rdy", b_rdy, 1);
    chk("b_rc_sue", b_sue, 1);
    chk("b_rc_idx", b_ci,  8'h08);
    chk("b_rc_err", b_err, ERR_EXP);
    tick;
    chk("b_rc_hold", b_cnt, 31);

    // async reset with a DONE entry about to retire
    b_irdy = 1'b1;
    tick;
    b_irdy = 1'b0;
    b_dv = 1'b1; b_di = 5'd9;
    tick;
    b_dv = 1'b0;
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("b_ar_cnt", b_cnt, 0);
    chk("b_ar_iv",  b_iv,  0);
    chk("b_ar_rdy", b_rdy, 1);
    chk("b_ar_sue", b_sue, 0);
    chk("b_ar_err", b_err, 0);
    tick;
    tick;
    b_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("b_post_sue", b_sue, 0);
    end
    chk("b_post_cnt", b_cnt, 0);
    chk("b_post_idx", b_ci,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
